// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN            = 2'd0,
    HAZ            = 2'd1,
    MEM_WAIT       = 2'd2,
    MEM_WAIT_REDIR = 2'd3
  } state_t;

  localparam int unsigned REG_AW_DEF = 5;

  // addi x0, x0, 0: what IF/ID holds after a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect.sv
// Combinational detector for load-use and ID-stage branch-operand hazards.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] IF_ID_rs1,
  input  logic [REG_AW-1:0] IF_ID_rs2,
  input  logic              ID_uses_rs1,
  input  logic              ID_uses_rs2,
  input  logic              ID_ctrl,
  input  logic [REG_AW-1:0] ID_EX_rd,
  input  logic              ID_EX_regwrite,
  input  logic              ID_EX_memread,
  input  logic [REG_AW-1:0] EX_MEM_rd,
  input  logic              EX_MEM_memread,
  output logic              hazard
);

  logic live_rs1, live_rs2;
  logic match_ex, match_mem;

  // x0 never carries a dependency, so a zero source is never live
  assign live_rs1  = ID_uses_rs1 && (IF_ID_rs1 != '0);
  assign live_rs2  = ID_uses_rs2 && (IF_ID_rs2 != '0);

  assign match_ex  = (live_rs1 && (ID_EX_rd == IF_ID_rs1)) ||
                     (live_rs2 && (ID_EX_rd == IF_ID_rs2));
  assign match_mem = (live_rs1 && (EX_MEM_rd == IF_ID_rs1)) ||
                     (live_rs2 && (EX_MEM_rd == IF_ID_rs2));

  assign hazard = (ID_EX_memread && match_ex) ||
                  (ID_ctrl && ((ID_EX_regwrite && match_ex) ||
                               (EX_MEM_memread && match_mem)));

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Define HAZARD_CTRL_PERF_EN to build the saturating performance counters.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_ID_rs1,
  input  logic [REG_AW-1:0] IF_ID_rs2,
  input  logic              ID_uses_rs1,
  input  logic              ID_uses_rs2,
  input  logic              ID_ctrl,
  input  logic [REG_AW-1:0] ID_EX_rd,
  input  logic              ID_EX_regwrite,
  input  logic              ID_EX_memread,
  input  logic [REG_AW-1:0] EX_MEM_rd,
  input  logic              EX_MEM_memread,
  input  logic              redirect,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  output logic              pc_en,
  output logic              IF_ID_en,
  output logic              ID_EX_en,
  output logic              EX_MEM_en,
  output logic              MEM_WB_en,
  output logic              pc_redirect,
  output logic              IF_ID_flush,
  output logic              ID_EX_bubble,
  output logic [CNT_W-1:0]  cnt_load_stall,
  output logic [CNT_W-1:0]  cnt_mem_stall,
  output logic [CNT_W-1:0]  cnt_flush
);

  state_t state_q, state_nxt;
  logic   hazard, mem_stall, redir_pend, redir_eff;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .IF_ID_rs1      (IF_ID_rs1),
    .IF_ID_rs2      (IF_ID_rs2),
    .ID_uses_rs1    (ID_uses_rs1),
    .ID_uses_rs2    (ID_uses_rs2),
    .ID_ctrl        (ID_ctrl),
    .ID_EX_rd       (ID_EX_rd),
    .ID_EX_regwrite (ID_EX_regwrite),
    .ID_EX_memread  (ID_EX_memread),
    .EX_MEM_rd      (EX_MEM_rd),
    .EX_MEM_memread (EX_MEM_memread),
    .hazard         (hazard)
  );

  assign mem_stall  = icache_stall | dcache_stall;
  assign redir_pend = (state_q == MEM_WAIT_REDIR);
  assign redir_eff  = redirect | redir_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_nxt;
  end

  always_comb begin
    pc_en        = 1'b0;
    IF_ID_en     = 1'b0;
    ID_EX_en     = 1'b0;
    EX_MEM_en    = 1'b0;
    MEM_WB_en    = 1'b0;
    pc_redirect  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    state_nxt    = RUN;
    if (rst_n) begin
      if (mem_stall) begin
        // a redirect arriving while frozen must survive until the stall ends
        state_nxt = redir_eff ? MEM_WAIT_REDIR : MEM_WAIT;
      end else if (redir_eff) begin
        {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = '1;
        pc_redirect  = 1'b1;
        IF_ID_flush  = 1'b1;
        ID_EX_bubble = 1'b1;
      end else if (hazard) begin
        ID_EX_en     = 1'b1;
        EX_MEM_en    = 1'b1;
        MEM_WB_en    = 1'b1;
        ID_EX_bubble = 1'b1;
        state_nxt    = HAZ;
      end else begin
        {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = '1;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] load_q, mem_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_q  <= '0;
      mem_q   <= '0;
      flush_q <= '0;
    end else begin
      if (mem_stall && mem_q != '1)
        mem_q <= mem_q + CNT_W'(1);
      if (!mem_stall && redir_eff && flush_q != '1)
        flush_q <= flush_q + CNT_W'(1);
      if (!mem_stall && !redir_eff && hazard && load_q != '1)
        load_q <= load_q + CNT_W'(1);
    end
  end

  assign cnt_load_stall = load_q;
  assign cnt_mem_stall  = mem_q;
  assign cnt_flush      = flush_q;
`else
  assign cnt_load_stall = '0;
  assign cnt_mem_stall  = '0;
  assign cnt_flush      = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller.
module tb_hazard_controller;

`ifdef HAZARD_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, pc_redirect, IF_ID_flush, ID_EX_bubble}
  localparam logic [7:0] V_RUN    = 8'b11111_000;
  localparam logic [7:0] V_FROZEN = 8'b00000_000;
  localparam logic [7:0] V_HAZ    = 8'b00111_001;
  localparam logic [7:0] V_FLUSH  = 8'b11111_111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
  logic       ID_uses_rs1, ID_uses_rs2, ID_ctrl;
  logic       ID_EX_regwrite, ID_EX_memread, EX_MEM_memread;
  logic       redirect, icache_stall, dcache_stall;
  logic       pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
  logic       pc_redirect, IF_ID_flush, ID_EX_bubble;
  logic [31:0] cnt_load_stall, cnt_mem_stall, cnt_flush;

  int unsigned tests_run = 0;
  int unsigned failures  = 0;

  hazard_controller #(.REG_AW(5), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IF_ID_rs1      (IF_ID_rs1),
    .IF_ID_rs2      (IF_ID_rs2),
    .ID_uses_rs1    (ID_uses_rs1),
    .ID_uses_rs2    (ID_uses_rs2),
    .ID_ctrl        (ID_ctrl),
    .ID_EX_rd       (ID_EX_rd),
    .ID_EX_regwrite (ID_EX_regwrite),
    .ID_EX_memread  (ID_EX_memread),
    .EX_MEM_rd      (EX_MEM_rd),
    .EX_MEM_memread (EX_MEM_memread),
    .redirect       (redirect),
    .icache_stall   (icache_stall),
    .dcache_stall   (dcache_stall),
    .pc_en          (pc_en),
    .IF_ID_en       (IF_ID_en),
    .ID_EX_en       (ID_EX_en),
    .EX_MEM_en      (EX_MEM_en),
    .MEM_WB_en      (MEM_WB_en),
    .pc_redirect    (pc_redirect),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_bubble   (ID_EX_bubble),
    .cnt_load_stall (cnt_load_stall),
    .cnt_mem_stall  (cnt_mem_stall),
    .cnt_flush      (cnt_flush)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
            pc_redirect, IF_ID_flush, ID_EX_bubble};
  endfunction

  function automatic logic [31:0] pc(input int unsigned v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic idle();
    IF_ID_rs1 = '0; IF_ID_rs2 = '0; ID_EX_rd = '0; EX_MEM_rd = '0;
    ID_uses_rs1 = 0; ID_uses_rs2 = 0; ID_ctrl = 0;
    ID_EX_regwrite = 0; ID_EX_memread = 0; EX_MEM_memread = 0;
    redirect = 0; icache_stall = 0; dcache_stall = 0;
  endtask

  // Inputs change just after a falling edge; outputs are sampled 1ns later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(); idle(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cyc(); idle(); rst_n = 1'b0; redirect = 1; ID_EX_memread = 1;
    ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd5; ID_uses_rs1 = 1;
    #1 tests_run++;
    if (outs() !== V_FROZEN) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", outs(), V_FROZEN);
    end
    cyc(); idle(); rst_n = 1'b1;
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL reset_release got=%b exp=%b", outs(), V_RUN);
    end
    tests_run++;
    if ({cnt_load_stall, cnt_mem_stall, cnt_flush} !== 96'd0) begin
      failures++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0",
                           cnt_load_stall, cnt_mem_stall, cnt_flush);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ID_EX_memread = 1; ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd5; ID_uses_rs1 = 1;
    #1 tests_run++;
    if (outs() !== V_HAZ) begin
      failures++; $display("FAIL load_use_stall got=%b exp=%b", outs(), V_HAZ);
    end
    cyc(); ID_EX_memread = 0; ID_EX_rd = '0;
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL load_use_resume got=%b exp=%b", outs(), V_RUN);
    end
    cyc(); idle();
    #1 tests_run++;
    if (cnt_load_stall !== pc(1)) begin
      failures++; $display("FAIL load_use_count got=%0d exp=%0d", cnt_load_stall, pc(1));
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    ID_EX_memread = 1; ID_EX_rd = 5'd0; IF_ID_rs1 = 5'd0; ID_uses_rs1 = 1;
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL rd_zero got=%b exp=%b", outs(), V_RUN);
    end
    cyc(); idle(); ID_EX_memread = 1; ID_EX_rd = 5'd9; IF_ID_rs2 = 5'd9; ID_uses_rs2 = 0;
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL unused_rs2 got=%b exp=%b", outs(), V_RUN);
    end
    cyc(); idle(); EX_MEM_memread = 1; EX_MEM_rd = 5'd6; IF_ID_rs1 = 5'd6; ID_uses_rs1 = 1;
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL mem_load_nonbranch got=%b exp=%b", outs(), V_RUN);
    end
    cyc(); idle(); ID_ctrl = 1; ID_EX_regwrite = 1; ID_EX_rd = 5'd4;
    IF_ID_rs2 = 5'd4; ID_uses_rs2 = 1;
    #1 tests_run++;
    if (outs() !== V_HAZ) begin
      failures++; $display("FAIL branch_alu_dep got=%b exp=%b", outs(), V_HAZ);
    end
    cyc(); idle();
  endtask

  task automatic test_load_branch();
    do_reset();
    ID_ctrl = 1; ID_uses_rs1 = 1; IF_ID_rs1 = 5'd7;
    ID_EX_memread = 1; ID_EX_regwrite = 1; ID_EX_rd = 5'd7;
    #1 tests_run++;
    if (outs() !== V_HAZ) begin
      failures++; $display("FAIL ld_br_haz1 got=%b exp=%b", outs(), V_HAZ);
    end
    cyc(); ID_EX_memread = 0; ID_EX_regwrite = 0; ID_EX_rd = '0;
    EX_MEM_memread = 1; EX_MEM_rd = 5'd7;
    #1 tests_run++;
    if (outs() !== V_HAZ) begin
      failures++; $display("FAIL ld_br_haz2 got=%b exp=%b", outs(), V_HAZ);
    end
    cyc(); EX_MEM_memread = 0; EX_MEM_rd = '0;
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL ld_br_run got=%b exp=%b", outs(), V_RUN);
    end
    cyc(); idle();
    #1 tests_run++;
    if (cnt_load_stall !== pc(2)) begin
      failures++; $display("FAIL ld_br_count got=%0d exp=%0d", cnt_load_stall, pc(2));
    end
  endtask

  task automatic test_redirect_dcache();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      dcache_stall = 1; redirect = (i == 1);
      #1 tests_run++;
      if (outs() !== V_FROZEN) begin
        failures++; $display("FAIL dstall_cycle%0d got=%b exp=%b", i, outs(), V_FROZEN);
      end
      cyc();
    end
    idle();
    #1 tests_run++;
    if (outs() !== V_FLUSH) begin
      failures++; $display("FAIL dstall_pending_flush got=%b exp=%b", outs(), V_FLUSH);
    end
    cyc();
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL dstall_after got=%b exp=%b", outs(), V_RUN);
    end
    tests_run++;
    if (cnt_mem_stall !== pc(4) || cnt_flush !== pc(1)) begin
      failures++; $display("FAIL dstall_counts got=%0d/%0d exp=%0d/%0d",
                           cnt_mem_stall, cnt_flush, pc(4), pc(1));
    end
  endtask

  task automatic test_redirect_hazard();
    do_reset();
    redirect = 1; ID_EX_memread = 1; ID_EX_rd = 5'd5; IF_ID_rs1 = 5'd5; ID_uses_rs1 = 1;
    #1 tests_run++;
    if (outs() !== V_FLUSH) begin
      failures++; $display("FAIL redir_haz_flush got=%b exp=%b", outs(), V_FLUSH);
    end
    cyc(); idle();
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL redir_haz_next got=%b exp=%b", outs(), V_RUN);
    end
    tests_run++;
    if (cnt_load_stall !== 32'd0 || cnt_flush !== pc(1)) begin
      failures++; $display("FAIL redir_haz_counts got=%0d/%0d exp=0/%0d",
                           cnt_load_stall, cnt_flush, pc(1));
    end
  endtask

  task automatic test_icache_plain();
    do_reset();
    icache_stall = 1;
    #1 tests_run++;
    if (outs() !== V_FROZEN) begin
      failures++; $display("FAIL istall got=%b exp=%b", outs(), V_FROZEN);
    end
    cyc(); cyc(); idle();
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL istall_release got=%b exp=%b", outs(), V_RUN);
    end
    tests_run++;
    if (cnt_mem_stall !== pc(2)) begin
      failures++; $display("FAIL istall_count got=%0d exp=%0d", cnt_mem_stall, pc(2));
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    icache_stall = 1; redirect = 1;
    cyc(); redirect = 0;
    cyc(); rst_n = 1'b0;
    #1 tests_run++;
    if (outs() !== V_FROZEN) begin
      failures++; $display("FAIL midrst_outputs got=%b exp=%b", outs(), V_FROZEN);
    end
    cyc(); rst_n = 1'b1; idle();
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL midrst_no_redirect got=%b exp=%b", outs(), V_RUN);
    end
    tests_run++;
    if ({cnt_load_stall, cnt_mem_stall, cnt_flush} !== 96'd0) begin
      failures++; $display("FAIL midrst_counters got=%0d/%0d/%0d exp=0/0/0",
                           cnt_load_stall, cnt_mem_stall, cnt_flush);
    end
    cyc();
    #1 tests_run++;
    if (outs() !== V_RUN) begin
      failures++; $display("FAIL midrst_steady got=%b exp=%b", outs(), V_RUN);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_no_stall();
    test_load_branch();
    test_redirect_dcache();
    test_redirect_hazard();
    test_icache_plain();
    test_reset_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
